// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_load_use_cmp.sv
// Load-use detector: the instruction in EX is a load whose destination the ID instruction reads.
module hazard_load_use_cmp #(
  parameter int unsigned REG_W = hazard_pkg::REG_W
) (
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic             memread,
  output logic             load_use_c
);
  import hazard_pkg::ZERO_REG;

  // $zero is never a real dependency, so a load targeting it cannot cause a stall.
  always_comb begin
    load_use_c = memread & (rd != REG_W'(ZERO_REG)) &
                 ((uses_rs1 & (rs1 == rd)) | (uses_rs2 & (rs2 == rd)));
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for load-use, taken-branch redirect and the iterative MUL/DIV unit.
// Control outputs are Mealy; only the stall performance counter is registered.
module pipeline_hazard_controller #(
  parameter int unsigned MULDIV_CYCLES = 8,
  parameter int unsigned REG_W         = hazard_pkg::REG_W,
  parameter int unsigned PERF_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  rs1_ifid,
  input  logic [REG_W-1:0]  rs2_ifid,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_W-1:0]  rd_idex,
  input  logic              memread_idex,
  input  logic              ex_is_muldiv,
  input  logic              branch_taken_ex,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_bubble,
  output logic              muldiv_start,
  output logic              muldiv_busy,
  output logic [PERF_W-1:0] stall_cycles
);
  import hazard_pkg::state_e;
  import hazard_pkg::RUN;
  import hazard_pkg::WAIT;

  localparam int unsigned CNT_W    = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam int unsigned CNT_INIT = (MULDIV_CYCLES >= 2) ? MULDIV_CYCLES - 2 : 0;
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

  hazard_load_use_cmp #(.REG_W(REG_W)) u_load_use_cmp (
    .rs1        (rs1_ifid),
    .rs2        (rs2_ifid),
    .rd         (rd_idex),
    .uses_rs1   (id_uses_rs1),
    .uses_rs2   (id_uses_rs2),
    .memread    (memread_idex),
    .load_use_c (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and Mealy outputs; reset forces the pipeline-free-running defaults.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    muldiv_start = 1'b0;
    muldiv_busy  = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (ex_is_muldiv) begin
            muldiv_start = 1'b1;
            if (MULDIV_CYCLES >= 2) begin
              pc_write     = 1'b0;
              ifid_write   = 1'b0;
              idex_write   = 1'b0;
              exmem_bubble = 1'b1;
              cnt_nxt      = CNT_W'(CNT_INIT);
              state_nxt    = WAIT;
            end
          end else if (branch_taken_ex) begin
            // The ID instruction is wrong-path, so any load-use it shows is moot.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        WAIT: begin
          muldiv_busy = 1'b1;
          if (cnt != '0) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            cnt_nxt      = cnt - CNT_W'(1);
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != PERF_MAX)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: an 8-cycle MUL/DIV build and a
// 1-cycle build with a 3-bit counter share the same stimulus.
module tb_pipeline_hazard_controller;

  // Output vector: {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, muldiv_start, muldiv_busy}
  localparam logic [7:0] DEF = 8'b1110_0000;
  localparam logic [7:0] LU  = 8'b0010_1000;
  localparam logic [7:0] BR  = 8'b1111_1000;
  localparam logic [7:0] STA = 8'b0000_0110;
  localparam logic [7:0] WT  = 8'b0000_0101;
  localparam logic [7:0] REL = 8'b1110_0001;
  localparam logic [7:0] ST1 = 8'b1110_0010;

  typedef struct packed {
    logic [4:0] a1, a2, d;
    logic       u1, u2, mr, md, br;
    logic [7:0] ex;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1_ifid = '0, rs2_ifid = '0, rd_idex = '0;
  logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, memread_idex = 1'b0;
  logic ex_is_muldiv = 1'b0, branch_taken_ex = 1'b0;

  logic pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, muldiv_start, muldiv_busy;
  logic [15:0] stall_cycles;
  logic pc_write1, ifid_write1, idex_write1, ifid_flush1, idex_bubble1, exmem_bubble1, muldiv_start1, muldiv_busy1;
  logic [2:0] stall_cycles1;

  logic [7:0] obs, obs1;
  assign obs  = {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, muldiv_start, muldiv_busy};
  assign obs1 = {pc_write1, ifid_write1, idex_write1, ifid_flush1, idex_bubble1, exmem_bubble1, muldiv_start1, muldiv_busy1};

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  logic [15:0] exp_stall = '0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MULDIV_CYCLES(8), .REG_W(5), .PERF_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .rd_idex(rd_idex),
    .memread_idex(memread_idex), .ex_is_muldiv(ex_is_muldiv), .branch_taken_ex(branch_taken_ex),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .muldiv_start(muldiv_start),
    .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  pipeline_hazard_controller #(.MULDIV_CYCLES(1), .REG_W(5), .PERF_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .rd_idex(rd_idex),
    .memread_idex(memread_idex), .ex_is_muldiv(ex_is_muldiv), .branch_taken_ex(branch_taken_ex),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .idex_write(idex_write1), .ifid_flush(ifid_flush1),
    .idex_bubble(idex_bubble1), .exmem_bubble(exmem_bubble1), .muldiv_start(muldiv_start1),
    .muldiv_busy(muldiv_busy1), .stall_cycles(stall_cycles1)
  );

  function automatic row_t mk(input logic [4:0] a1_i, a2_i, d_i,
                              input logic u1_i, u2_i, mr_i, md_i, br_i, input logic [7:0] ex_i);
    row_t r;
    r.a1 = a1_i; r.a2 = a2_i; r.d = d_i;
    r.u1 = u1_i; r.u2 = u2_i; r.mr = mr_i; r.md = md_i; r.br = br_i;
    r.ex = ex_i;
    return r;
  endfunction

  task automatic apply(input row_t r);
    rs1_ifid = r.a1; rs2_ifid = r.a2; rd_idex = r.d;
    id_uses_rs1 = r.u1; id_uses_rs2 = r.u2; memread_idex = r.mr;
    ex_is_muldiv = r.md; branch_taken_ex = r.br;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF));
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_stall = '0;
  endtask

  task automatic test_reset();
    apply(mk(8, 8, 8, 1, 1, 1, 1, 1, DEF));
    @(negedge clk);
    total++;
    if (obs !== DEF) begin bad++; $display("FAIL reset_outputs obs=%b exp=%b", obs, DEF); end
    total++;
    if (obs1 !== DEF) begin bad++; $display("FAIL reset_outputs_m1 obs=%b exp=%b", obs1, DEF); end
    total++;
    if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_stall obs=%0d exp=0", stall_cycles); end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF));
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_stall = '0;
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [7:0] e;
    rows.push_back(mk(8, 0, 8, 1, 0, 1, 0, 0, LU));
    rows.push_back(mk(0, 5, 5, 0, 1, 1, 0, 0, LU));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL load_use row%0d obs=%b exp=%b", i, obs, e); end
      if (!e[7]) exp_stall++;
      @(posedge clk); #1;
    end
    total++;
    if (stall_cycles !== exp_stall) begin bad++; $display("FAIL load_use_stall obs=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_no_stall();
    row_t rows[$];
    logic [7:0] e;
    rows.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, DEF));
    rows.push_back(mk(8, 8, 8, 0, 0, 1, 0, 0, DEF));
    rows.push_back(mk(8, 8, 8, 1, 1, 0, 0, 0, DEF));
    rows.push_back(mk(3, 4, 8, 1, 1, 1, 0, 0, DEF));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL no_stall row%0d obs=%b exp=%b", i, obs, e); end
      if (!e[7]) exp_stall++;
      @(posedge clk); #1;
    end
    total++;
    if (stall_cycles !== exp_stall) begin bad++; $display("FAIL no_stall_count obs=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_branch();
    row_t rows[$];
    logic [7:0] e;
    rows.push_back(mk(8, 0, 8, 1, 0, 1, 0, 1, BR));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, BR));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL branch row%0d obs=%b exp=%b", i, obs, e); end
      if (!e[7]) exp_stall++;
      @(posedge clk); #1;
    end
    total++;
    if (stall_cycles !== exp_stall) begin bad++; $display("FAIL branch_stall obs=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  // Start cycle carries an illegal branch; WAIT cycles carry branch and load-use noise.
  task automatic test_muldiv();
    row_t rows[$];
    logic [7:0] e;
    do_reset();
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, STA));
    for (int k = 0; k < 6; k++) rows.push_back(mk(8, 8, 8, 1, 1, 1, 1, 1'((k % 2) == 0), WT));
    rows.push_back(mk(8, 8, 8, 1, 1, 1, 1, 1, REL));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL muldiv row%0d obs=%b exp=%b", i, obs, e); end
      if (!e[7]) exp_stall++;
      @(posedge clk); #1;
    end
    total++;
    if (stall_cycles !== exp_stall) begin bad++; $display("FAIL muldiv_stall obs=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_reset_mid_wait();
    row_t rows[$];
    logic [7:0] e;
    do_reset();
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, STA));
    for (int k = 0; k < 4; k++) rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, WT));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL mid_wait row%0d obs=%b exp=%b", i, obs, e); end
      if (!e[7]) exp_stall++;
      if (i < rows.size() - 1) begin @(posedge clk); #1; end
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== DEF) begin bad++; $display("FAIL mid_wait_reset obs=%b exp=%b", obs, DEF); end
    total++;
    if (stall_cycles !== 16'd0) begin bad++; $display("FAIL mid_wait_reset_stall obs=%0d exp=0", stall_cycles); end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF));
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_stall = '0;
    @(negedge clk);
    total++;
    if (obs !== DEF) begin bad++; $display("FAIL mid_wait_after obs=%b exp=%b", obs, DEF); end
    total++;
    if (stall_cycles !== 16'd0) begin bad++; $display("FAIL mid_wait_after_stall obs=%0d exp=0", stall_cycles); end
    @(posedge clk); #1;
  endtask

  task automatic test_muldiv_one();
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 1'(i == 0), 0, DEF));
      exp1_q.push_back((i == 0) ? ST1 : DEF);
      @(negedge clk);
      e = exp1_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL muldiv_one row%0d obs=%b exp=%b", i, obs1, e); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_cycles1 !== 3'd0) begin bad++; $display("FAIL muldiv_one_stall obs=%0d exp=0", stall_cycles1); end
  endtask

  task automatic test_saturate();
    logic [7:0] e;
    logic [2:0] exp1 = '0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(mk(9, 0, 9, 1, 0, 1, 0, 0, LU));
      exp1_q.push_back(LU);
      @(negedge clk);
      e = exp1_q.pop_front();
      total++;
      if (obs1 !== e) begin bad++; $display("FAIL saturate row%0d obs=%b exp=%b", i, obs1, e); end
      if (exp1 != 3'd7) exp1++;
      exp_stall++;
      @(posedge clk); #1;
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, DEF));
    total++;
    if (stall_cycles1 !== exp1) begin bad++; $display("FAIL saturate_count obs=%0d exp=%0d", stall_cycles1, exp1); end
    total++;
    if (stall_cycles !== exp_stall) begin bad++; $display("FAIL saturate_main obs=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  // Release cycle ignores a held MUL/DIV and a load-use; the very next RUN cycle honours load-use.
  task automatic test_back_to_back();
    row_t rows[$];
    logic [7:0] e;
    do_reset();
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, STA));
    for (int k = 0; k < 6; k++) rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, WT));
    rows.push_back(mk(7, 0, 7, 1, 0, 1, 1, 0, REL));
    rows.push_back(mk(7, 0, 7, 1, 0, 1, 0, 0, LU));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, STA));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, WT));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL back_to_back row%0d obs=%b exp=%b", i, obs, e); end
      if (!e[7]) exp_stall++;
      @(posedge clk); #1;
    end
    total++;
    if (stall_cycles !== exp_stall) begin bad++; $display("FAIL back_to_back_stall obs=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_muldiv();
    test_reset_mid_wait();
    test_muldiv_one();
    test_saturate();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
